// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    typedef enum logic {OWN_IF, OWN_MEM} owner_e;

    localparam logic [2:0] FUNCT3_LWU = 3'b110;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester (IF, MEM) and cache-side signals of the shared data-cache port.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_rvalid_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              mem_req_i;
    logic              mem_we_i;
    logic [2:0]        mem_funct3_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_rvalid_o;
    logic [DATA_W-1:0] mem_rdata_o;

    logic              cache_req_o;
    logic              cache_we_o;
    logic [2:0]        cache_funct3_o;
    logic [ADDR_W-1:0] cache_addr_o;
    logic [DATA_W-1:0] cache_wdata_o;
    logic              cache_gnt_i;
    logic              cache_rvalid_i;
    logic [DATA_W-1:0] cache_rdata_i;

    logic              err_o;

    // Arbiter view: serves the requesters and masters the cache.
    modport slave (
        input  if_req_i, if_addr_i,
        output if_rvalid_o, if_rdata_o,
        input  mem_req_i, mem_we_i, mem_funct3_i, mem_addr_i, mem_wdata_i,
        output mem_rvalid_o, mem_rdata_o,
        output cache_req_o, cache_we_o, cache_funct3_o, cache_addr_o, cache_wdata_o,
        input  cache_gnt_i, cache_rvalid_i, cache_rdata_i,
        output err_o
    );

    // Environment view: requesters plus the cache.
    modport master (
        output if_req_i, if_addr_i,
        input  if_rvalid_o, if_rdata_o,
        output mem_req_i, mem_we_i, mem_funct3_i, mem_addr_i, mem_wdata_i,
        input  mem_rvalid_o, mem_rdata_o,
        input  cache_req_o, cache_we_o, cache_funct3_o, cache_addr_o, cache_wdata_o,
        output cache_gnt_i, cache_rvalid_i, cache_rdata_i,
        input  err_o
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Response watchdog: counts enabled cycles, flags expiry at TIMEOUT_CYC-1.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned CntW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = en_i && (cnt_q == CntW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-cache port between instruction fetch and the MEM stage,
// one transaction at a time, with an IF starvation guard and a response watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 64,
    parameter int unsigned DATA_W       = 64,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT_CYC  = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    mem_port_arbiter_if.slave   bus
);
    localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic                expired;

    mem_arb_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (state_q == IDLE),
        .en_i      ((state_q == ISSUE) || (state_q == WAIT)),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            owner_q  <= OWN_IF;
            streak_q <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            funct3_q <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            streak_q <= streak_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        streak_d = streak_q;
        addr_d   = addr_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.if_req_i || bus.mem_req_i) begin
                    state_d = ISSUE;
                    err_d   = 1'b0;
                    // MEM has priority unless IF has watched STARVE_LIMIT MEM grants go by.
                    if (bus.mem_req_i && !(bus.if_req_i && streak_q == StreakMax)) begin
                        owner_d  = OWN_MEM;
                        addr_d   = bus.mem_addr_i;
                        we_d     = bus.mem_we_i;
                        funct3_d = bus.mem_funct3_i;
                        wdata_d  = bus.mem_wdata_i;
                        if (!bus.if_req_i) begin
                            streak_d = '0;
                        end else if (streak_q != StreakMax) begin
                            streak_d = streak_q + 1'b1;
                        end
                    end else begin
                        owner_d  = OWN_IF;
                        addr_d   = bus.if_addr_i;
                        we_d     = 1'b0;
                        funct3_d = FUNCT3_LWU;
                        wdata_d  = '0;
                        streak_d = '0;
                    end
                end
            end
            ISSUE: begin
                if (bus.cache_gnt_i) begin
                    state_d = WAIT;
                end else if (expired) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            WAIT: begin
                if (bus.cache_rvalid_i) begin
                    state_d = RESP;
                    rdata_d = we_q ? '0 : bus.cache_rdata_i;
                    err_d   = 1'b0;
                end else if (expired) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    logic issue, resp;
    assign issue = (state_q == ISSUE);
    assign resp  = (state_q == RESP);

    assign bus.cache_req_o    = issue;
    assign bus.cache_we_o     = issue && we_q;
    assign bus.cache_funct3_o = issue ? funct3_q : 3'b000;
    assign bus.cache_addr_o   = issue ? addr_q : '0;
    assign bus.cache_wdata_o  = issue ? wdata_q : '0;

    assign bus.if_rvalid_o  = resp && (owner_q == OWN_IF);
    assign bus.if_rdata_o   = bus.if_rvalid_o ? rdata_q : '0;
    assign bus.mem_rvalid_o = resp && (owner_q == OWN_MEM);
    assign bus.mem_rdata_o  = bus.mem_rvalid_o ? rdata_q : '0;
    assign bus.err_o        = resp && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; inputs driven and outputs sampled on negedge.
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_port_arbiter #(
        .ADDR_W       (64),
        .DATA_W       (64),
        .STARVE_LIMIT (4),
        .TIMEOUT_CYC  (64)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int if_rv_cnt = 0;
    int mem_rv_cnt = 0;

    always @(negedge clk) begin
        if (bus.if_rvalid_o)  if_rv_cnt  <= if_rv_cnt + 1;
        if (bus.mem_rvalid_o) mem_rv_cnt <= mem_rv_cnt + 1;
    end

    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic        cap_we;
    logic [2:0]  cap_f3;
    int          wait_cyc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Waits for cache_req_o, withholds gnt for gnt_dly cycles, then returns a response.
    // Returns at the negedge of the RESP cycle.
    task automatic serve(input int gnt_dly, input logic [63:0] data);
        wait_cyc = 0;
        while (!bus.cache_req_o && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!bus.cache_req_o) begin
            check("cache_req_timeout", 64'(bus.cache_req_o), 64'd1);
            return;
        end
        cap_addr  = bus.cache_addr_o;
        cap_wdata = bus.cache_wdata_o;
        cap_we    = bus.cache_we_o;
        cap_f3    = bus.cache_funct3_o;
        for (int i = 0; i < gnt_dly; i++) begin
            @(negedge clk);
            check("stall_req", 64'(bus.cache_req_o), 64'd1);
            check("stall_addr", bus.cache_addr_o, cap_addr);
            check("stall_f3", 64'(bus.cache_funct3_o), 64'(cap_f3));
        end
        bus.cache_gnt_i = 1'b1;
        @(negedge clk);
        bus.cache_gnt_i    = 1'b0;
        bus.cache_rvalid_i = 1'b1;
        bus.cache_rdata_i  = data;
        @(negedge clk);
        bus.cache_rvalid_i = 1'b0;
        bus.cache_rdata_i  = '0;
    endtask

    int snap_if;
    int snap_mem;
    int cnt;
    logic [3:0] own_seen;

    initial begin
        rst_n = 1'b0;
        bus.if_req_i = 1'b0;       bus.if_addr_i = '0;
        bus.mem_req_i = 1'b0;      bus.mem_we_i = 1'b0;
        bus.mem_funct3_i = 3'b000; bus.mem_addr_i = '0;  bus.mem_wdata_i = '0;
        bus.cache_gnt_i = 1'b0;    bus.cache_rvalid_i = 1'b0; bus.cache_rdata_i = '0;
        repeat (2) @(negedge clk);
        check("rst_cache_req", 64'(bus.cache_req_o), 64'd0);
        check("rst_outputs", 64'({bus.if_rvalid_o, bus.mem_rvalid_o, bus.err_o}), 64'd0);
        check("rst_addr", bus.cache_addr_o, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single IF fetch.
        snap_mem = mem_rv_cnt;
        snap_if  = if_rv_cnt;
        bus.if_req_i = 1'b1; bus.if_addr_i = 64'h1000;
        serve(0, 64'hDEAD_BEEF);
        check("if_latency", 64'(wait_cyc), 64'd1);
        check("if_addr", cap_addr, 64'h1000);
        check("if_funct3", 64'(cap_f3), 64'd6);
        check("if_we", 64'(cap_we), 64'd0);
        check("if_rvalid", 64'(bus.if_rvalid_o), 64'd1);
        check("if_rdata", bus.if_rdata_o, 64'hDEAD_BEEF);
        bus.if_req_i = 1'b0;
        @(negedge clk);
        check("if_rvalid_pulse", 64'(bus.if_rvalid_o), 64'd0);
        @(negedge clk);
        check("if_rv_once", 64'(if_rv_cnt - snap_if), 64'd1);
        check("if_no_mem_rv", 64'(mem_rv_cnt - snap_mem), 64'd0);

        // Simultaneous requests: MEM store first, then IF.
        bus.if_req_i = 1'b1; bus.if_addr_i = 64'h1004;
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 64'h2000;
        bus.mem_wdata_i = 64'h55; bus.mem_funct3_i = 3'b011;
        serve(0, 64'hBAD0_BAD0);
        check("st_we", 64'(cap_we), 64'd1);
        check("st_addr", cap_addr, 64'h2000);
        check("st_wdata", cap_wdata, 64'h55);
        check("st_funct3", 64'(cap_f3), 64'd3);
        check("st_mem_rvalid", 64'(bus.mem_rvalid_o), 64'd1);
        check("st_mem_rdata", bus.mem_rdata_o, 64'd0);
        check("st_if_rvalid", 64'(bus.if_rvalid_o), 64'd0);
        bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0;
        serve(0, 64'h1234);
        check("if2_addr", cap_addr, 64'h1004);
        check("if2_rvalid", 64'(bus.if_rvalid_o), 64'd1);
        check("if2_rdata", bus.if_rdata_o, 64'h1234);
        bus.if_req_i = 1'b0;
        @(negedge clk);

        // Starvation guard: 4 MEM grants, then IF, then MEM again.
        bus.if_req_i = 1'b1; bus.if_addr_i = 64'h3000;
        bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 64'h4000;
        bus.mem_funct3_i = 3'b011;
        for (int k = 0; k < 6; k++) begin
            serve(0, 64'(k + 16));
            own_seen = {2'b00, bus.if_rvalid_o, bus.mem_rvalid_o};
            check($sformatf("starve_owner%0d", k), 64'(own_seen), (k == 4) ? 64'd2 : 64'd1);
            if (k != 4) check($sformatf("starve_rdata%0d", k), bus.mem_rdata_o, 64'(k + 16));
            if (bus.if_rvalid_o) bus.if_req_i = 1'b0;
        end
        bus.mem_req_i = 1'b0;
        @(negedge clk);

        // Grant withheld 3 cycles; MEM address change after capture must not leak.
        bus.mem_req_i = 1'b1; bus.mem_addr_i = 64'h5000; bus.mem_funct3_i = 3'b010;
        @(negedge clk);
        bus.mem_addr_i = 64'hFFFF;
        serve(3, 64'hCAFE);
        check("stall_cap_addr", cap_addr, 64'h5000);
        check("stall_rvalid", 64'(bus.mem_rvalid_o), 64'd1);
        check("stall_rdata", bus.mem_rdata_o, 64'hCAFE);
        bus.mem_req_i = 1'b0;
        @(negedge clk);

        // Watchdog: granted but never answered.
        bus.if_req_i = 1'b1; bus.if_addr_i = 64'h6000;
        cnt = 0;
        while (!bus.cache_req_o && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        bus.cache_gnt_i = 1'b1;
        @(negedge clk);
        bus.cache_gnt_i = 1'b0;
        cnt = 1;
        while (!bus.if_rvalid_o && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("wd_cycles", 64'(cnt), 64'd64);
        check("wd_err", 64'(bus.err_o), 64'd1);
        check("wd_rdata", bus.if_rdata_o, 64'd0);
        bus.if_req_i = 1'b0;
        @(negedge clk);
        check("wd_idle", 64'({bus.cache_req_o, bus.if_rvalid_o, bus.err_o}), 64'd0);

        // Reset during WAIT; a late cache response is ignored.
        snap_if  = if_rv_cnt;
        snap_mem = mem_rv_cnt;
        bus.mem_req_i = 1'b1; bus.mem_addr_i = 64'h7000; bus.mem_funct3_i = 3'b011;
        cnt = 0;
        while (!bus.cache_req_o && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        bus.cache_gnt_i = 1'b1;
        @(negedge clk);
        bus.cache_gnt_i = 1'b0;
        rst_n = 1'b0;
        bus.mem_req_i = 1'b0;
        @(negedge clk);
        check("rst_wait_outs", 64'({bus.cache_req_o, bus.if_rvalid_o, bus.mem_rvalid_o,
                                    bus.err_o}), 64'd0);
        rst_n = 1'b1;
        bus.cache_rvalid_i = 1'b1; bus.cache_rdata_i = 64'h99;
        @(negedge clk);
        bus.cache_rvalid_i = 1'b0; bus.cache_rdata_i = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_no_rvalid", 64'((if_rv_cnt - snap_if) + (mem_rv_cnt - snap_mem)), 64'd0);
        check("rst_idle", 64'(bus.cache_req_o), 64'd0);
        bus.if_req_i = 1'b1; bus.if_addr_i = 64'h8000;
        serve(0, 64'h77);
        check("post_rst_rvalid", 64'(bus.if_rvalid_o), 64'd1);
        check("post_rst_rdata", bus.if_rdata_o, 64'h77);
        bus.if_req_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
